// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: instruction-memory sizing parameters and loader state encoding
package pkg_parameters;
   localparam int IMEM_CAPACITY_KiB = 1;
   localparam int ILEN = 32;
   localparam int IMEM_WORDS = IMEM_CAPACITY_KiB * 256;
   localparam int IMEM_AW = $clog2(IMEM_CAPACITY_KiB * 1024);
endpackage

package imem_loader_pkg;
   typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_FIN, S_DONE, S_ERR} loader_state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four accepted stream bytes into one little-endian 32-bit word
module byte_packer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        fire_i,
   input  logic [7:0]  data_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);
   logic [1:0] lane_q, lane_d;
   logic [23:0] shift_q, shift_d;
   always_comb begin
      word_valid_o = fire_i && lane_q == 2'd3;
      word_o = {data_i, shift_q};
      lane_d = clear_i ? '0 : fire_i ? lane_q + 2'd1 : lane_q;
      shift_d = clear_i ? '0 : fire_i ? {data_i, shift_q[23:8]} : shift_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lane_q <= '0;
         shift_q <= '0;
      end else begin
         lane_q <= lane_d;
         shift_q <= shift_d;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a length-prefixed image into instruction memory, holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require and verify a trailing 32-bit sum-of-words checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_CAPACITY_KiB = pkg_parameters::IMEM_CAPACITY_KiB,
   parameter int ILEN = pkg_parameters::ILEN
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic                                      byte_valid_i,
   input  logic [7:0]                                byte_data_i,
   output logic                                      byte_ready_o,
   output logic                                      imem_we_o,
   output logic [$clog2(IMEM_CAPACITY_KiB*1024)-1:0] imem_addr_o,
   output logic [ILEN-1:0]                           imem_wdata_o,
   output logic                                      cpu_rst_o,
   output logic                                      done_o,
   output logic                                      err_o
);
   localparam int WORDS = IMEM_CAPACITY_KiB * 256;
   localparam int AW = $clog2(IMEM_CAPACITY_KiB * 1024);
   localparam int IW = $clog2(WORDS + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_e S_TAIL = S_CSUM;
   logic [31:0] sum_q, sum_d;
`else
   localparam loader_state_e S_TAIL = S_FIN;
`endif
   loader_state_e state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [31:0] n_q, n_d;
   logic ready_q, ready_d, we_q, we_d, cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [ILEN-1:0] wdata_q, wdata_d;
   logic fire, word_valid;
   logic [31:0] word;

   assign fire = byte_valid_i && ready_q;

   byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (!ready_q),
      .fire_i      (fire),
      .data_i      (byte_data_i),
      .word_valid_o(word_valid),
      .word_o      (word)
   );

   always_comb begin
      state_d = state_q;
      i_d = i_q;
      n_d = n_q;
      we_d = 1'b0;
      addr_d = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d = sum_q;
`endif
      case (state_q)
         S_LEN: if (word_valid) begin
            n_d = word;
            state_d = word > 32'(WORDS) ? S_ERR : word == '0 ? S_TAIL : S_DATA;
         end
         S_DATA: if (word_valid) begin
            we_d = 1'b1;
            addr_d = AW'({i_q, 2'b00});
            wdata_d = ILEN'(word);
            i_d = i_q + IW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d = sum_q + word;
`endif
            state_d = 32'(i_d) == n_q ? S_TAIL : S_DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: if (word_valid) state_d = word == sum_q ? S_FIN : S_ERR;
`endif
         S_FIN: state_d = S_DONE;
         default: ;
      endcase
      // Status flags follow the next state so they line up with the state they describe
      ready_d = state_d inside {S_LEN, S_DATA, S_CSUM};
      cpu_rst_d = state_d != S_DONE;
      done_d = state_d == S_DONE;
      err_d = state_d == S_ERR;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_LEN;
         i_q <= '0;
         n_q <= '0;
         ready_q <= 1'b1;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         cpu_rst_q <= 1'b1;
         done_q <= 1'b0;
         err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         i_q <= i_d;
         n_q <= n_d;
         ready_q <= ready_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         cpu_rst_q <= cpu_rst_d;
         done_q <= done_d;
         err_q <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q <= sum_d;
`endif
      end
   end

   assign byte_ready_o = ready_q;
   assign imem_we_o = we_q;
   assign imem_addr_o = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_rst_o = cpu_rst_q;
   assign done_o = done_q;
   assign err_o = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against an image-level reference model
`timescale 1ns/1ps
module tb_imem_loader;
   import pkg_parameters::*;
   localparam int AW = IMEM_AW;
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
   } wr_t;

   logic clk_i = 1'b0, rst_i = 1'b1, byte_valid_i = 1'b0;
   logic [7:0] byte_data_i = '0;
   logic byte_ready_o, imem_we_o, cpu_rst_o, done_o, err_o;
   logic [AW-1:0] imem_addr_o;
   logic [ILEN-1:0] imem_wdata_o;
   int checks = 0, fails = 0;
   int cyc = 0, done_cyc = -1, we_wide = 0, rst_bad = 0;
   logic prev_we = 1'b0, prev_done = 1'b0;
   wr_t wq[$];
   wr_t mon_e;
   int acc_q[$];

   imem_loader dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .byte_valid_i(byte_valid_i),
      .byte_data_i (byte_data_i),
      .byte_ready_o(byte_ready_o),
      .imem_we_o   (imem_we_o),
      .imem_addr_o (imem_addr_o),
      .imem_wdata_o(imem_wdata_o),
      .cpu_rst_o   (cpu_rst_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Write/completion monitor, sampled on the falling edge
   always @(negedge clk_i) begin
      if (rst_i) begin
         wq.delete();
         done_cyc <= -1;
         we_wide <= 0;
         rst_bad <= 0;
      end else begin
         if (imem_we_o) begin
            mon_e.addr = imem_addr_o;
            mon_e.data = imem_wdata_o;
            mon_e.cyc = cyc;
            wq.push_back(mon_e);
         end
         if (imem_we_o && prev_we) we_wide <= we_wide + 1;
         if (done_o && !prev_done) done_cyc <= cyc;
         if (cpu_rst_o !== !done_o) rst_bad <= rst_bad + 1;
      end
      prev_we <= imem_we_o;
      prev_done <= done_o;
   end

   function automatic logic [31:0] sum_words(input logic [31:0] w[$]);
      logic [31:0] s = 0;
      foreach (w[k]) s += w[k];
      return s;
   endfunction

   function automatic bit exp_ok(input logic [31:0] n, input logic [31:0] w[$], input logic [31:0] cs);
      if (n > 32'(IMEM_WORDS)) return 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      return sum_words(w) == cs;
`else
      return cs == cs;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      byte_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      acc_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      byte_valid_i = 1'b1;
      byte_data_i = b;
      while (!byte_ready_o && t < 20) begin
         @(negedge clk_i);
         t++;
      end
      if (!byte_ready_o) begin
         checks++;
         fails++;
         $display("FAIL handshake: byte_ready_o=%b required=1 after %0d cycles", byte_ready_o, t);
      end
      @(negedge clk_i);
      acc_q.push_back(cyc);
      byte_valid_i = 1'b0;
      if (gap) @(negedge clk_i);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_mode);
      for (int k = 0; k < 4; k++)
         send_byte(w[8*k +: 8], gap_mode == 2 ? bit'($urandom_range(0, 1)) : gap_mode == 1);
   endtask

   task automatic send_image(input logic [31:0] n, input logic [31:0] w[$], input logic [31:0] cs, input int gap_mode);
      send_word(n, gap_mode);
      foreach (w[k]) send_word(w[k], gap_mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(cs, gap_mode);
`else
      if (cs != cs) send_word(cs, gap_mode);
`endif
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(done_o || err_o) && t < 40) begin
         @(negedge clk_i);
         t++;
      end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      checks += 7;
      if (byte_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", byte_ready_o); end
      if (imem_we_o !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", imem_we_o); end
      if (imem_addr_o !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr_o); end
      if (imem_wdata_o !== '0) begin fails++; $display("FAIL reset_wdata: got %h want 0", imem_wdata_o); end
      if (cpu_rst_o !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst_o); end
      if (done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
      if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_o); end
   endtask

   task automatic test_image(input string name, input int gap_mode);
      logic [31:0] w[$] = '{32'h00000013, 32'h00100093, 32'h00208133};
      do_reset();
      send_image(3, w, sum_words(w), gap_mode);
      wait_end();
      checks++;
      if (wq.size() != 3) begin fails++; $display("FAIL %s_write_count: got %0d want 3", name, wq.size()); end
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         checks += 3;
         if (wq[i].addr !== AW'(i * 4)) begin fails++; $display("FAIL %s_addr[%0d]: got %h want %h", name, i, wq[i].addr, AW'(i * 4)); end
         if (wq[i].data !== w[i]) begin fails++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, wq[i].data, w[i]); end
         if (wq[i].cyc != acc_q[4 * i + 7]) begin fails++; $display("FAIL %s_latency[%0d]: write cycle %0d want %0d", name, i, wq[i].cyc, acc_q[4 * i + 7]); end
      end
      checks += 5;
      if (done_cyc != acc_q[acc_q.size() - 1] + 1) begin fails++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, acc_q[acc_q.size() - 1] + 1); end
      if (done_o !== 1'b1 || err_o !== 1'b0) begin fails++; $display("FAIL %s_status: done=%b err=%b want done=1 err=0", name, done_o, err_o); end
      if (cpu_rst_o !== 1'b0) begin fails++; $display("FAIL %s_cpu_rst: got %b want 0", name, cpu_rst_o); end
      if (we_wide != 0) begin fails++; $display("FAIL %s_we_pulse: %0d multi-cycle strobes want 0", name, we_wide); end
      if (rst_bad != 0) begin fails++; $display("FAIL %s_cpu_rst_vs_done: %0d cycles disagree want 0", name, rst_bad); end
   endtask

   task automatic test_back_to_back();
      test_image("b2b", 0);
   endtask

   task automatic test_toggle();
      test_image("toggle", 1);
   endtask

   task automatic test_zero_len();
      logic [31:0] w[$];
      do_reset();
      send_image(0, w, 0, 0);
      wait_end();
      checks += 3;
      if (wq.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wq.size()); end
      if (done_o !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done_o); end
      if (done_cyc != acc_q[acc_q.size() - 1] + 1) begin fails++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, acc_q[acc_q.size() - 1] + 1); end
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(32'(IMEM_WORDS + 1), 0);
      byte_valid_i = 1'b1;
      byte_data_i = 8'hA5;
      repeat (6) @(negedge clk_i);
      byte_valid_i = 1'b0;
      checks += 5;
      if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", err_o); end
      if (byte_ready_o !== 1'b0) begin fails++; $display("FAIL ovf_ready: got %b want 0", byte_ready_o); end
      if (cpu_rst_o !== 1'b1) begin fails++; $display("FAIL ovf_cpu_rst: got %b want 1", cpu_rst_o); end
      if (done_o !== 1'b0) begin fails++; $display("FAIL ovf_done: got %b want 0", done_o); end
      if (wq.size() != 0) begin fails++; $display("FAIL ovf_writes: got %0d want 0", wq.size()); end
   endtask

   task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [31:0] w[$] = '{32'hFFFFFFFF, 32'h00000002};
      for (int c = 1; c <= 2; c++) begin
         do_reset();
         send_image(2, w, 32'(c), 0);
         wait_end();
         checks += 3;
         if (done_o !== (c == 1)) begin fails++; $display("FAIL csum%0d_done: got %b want %b", c, done_o, c == 1); end
         if (err_o !== (c == 2)) begin fails++; $display("FAIL csum%0d_err: got %b want %b", c, err_o, c == 2); end
         if (wq.size() != 2) begin fails++; $display("FAIL csum%0d_writes: got %0d want 2", c, wq.size()); end
      end
`endif
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         logic [31:0] w[$];
         logic [31:0] cs;
         bit ok;
         int n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) w.push_back($urandom);
         cs = sum_words(w) + 32'($urandom_range(0, 1));
         ok = exp_ok(32'(n), w, cs);
         do_reset();
         send_image(32'(n), w, cs, 2);
         wait_end();
         checks += 4;
         if (done_o !== ok || err_o !== !ok) begin fails++; $display("FAIL rand%0d_status: done=%b err=%b want done=%b", it, done_o, err_o, ok); end
         if (wq.size() != n) begin fails++; $display("FAIL rand%0d_writes: got %0d want %0d", it, wq.size(), n); end
         if (we_wide != 0) begin fails++; $display("FAIL rand%0d_we_pulse: got %0d want 0", it, we_wide); end
         if (rst_bad != 0) begin fails++; $display("FAIL rand%0d_cpu_rst: got %0d want 0", it, rst_bad); end
         for (int i = 0; i < n && i < wq.size(); i++) begin
            checks++;
            if (wq[i].addr !== AW'(i * 4) || wq[i].data !== w[i]) begin
               fails++;
               $display("FAIL rand%0d_write[%0d]: got %h:%h want %h:%h", it, i, wq[i].addr, wq[i].data, AW'(i * 4), w[i]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] w[$] = '{32'h00000013, 32'h00100093, 32'h00208133};
      do_reset();
      send_word(3, 0);
      for (int k = 0; k < 6; k++) send_byte(w[k / 4][8 * (k % 4) +: 8], 0);
      rst_i = 1'b1;
      #1;
      checks += 5;
      if (byte_ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", byte_ready_o); end
      if (imem_addr_o !== '0 || imem_wdata_o !== '0) begin fails++; $display("FAIL midrst_write_regs: addr=%h data=%h want 0", imem_addr_o, imem_wdata_o); end
      if (imem_we_o !== 1'b0) begin fails++; $display("FAIL midrst_we: got %b want 0", imem_we_o); end
      if (cpu_rst_o !== 1'b1) begin fails++; $display("FAIL midrst_cpu_rst: got %b want 1", cpu_rst_o); end
      if (done_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL midrst_status: done=%b err=%b want 0", done_o, err_o); end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      acc_q.delete();
      send_image(3, w, sum_words(w), 0);
      wait_end();
      checks += 2;
      if (wq.size() != 3 || done_o !== 1'b1) begin fails++; $display("FAIL midrst_reload: writes=%0d done=%b want 3 1", wq.size(), done_o); end
      if (wq.size() == 0 || wq[0].addr !== '0 || wq[0].data !== w[0]) begin
         fails++;
         $display("FAIL midrst_first_write: got %h:%h want 0:%h", wq.size() ? wq[0].addr : '1, wq.size() ? wq[0].data : '1, w[0]);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_toggle();
      test_zero_len();
      test_overflow();
      test_checksum();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the instruction memory and the CPU core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from byte address 0. It holds the CPU in reset until the image is complete, so execution always starts from a fully loaded program.

## Interface
Parameters:
- `IMEM_CAPACITY_KiB`, default `pkg_parameters::IMEM_CAPACITY_KiB`: instruction memory size; sets the word limit and the address width.
- `ILEN`, default `pkg_parameters::ILEN` (32): instruction word width.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `byte_valid_i`, input, 1: a stream byte is present.
- `byte_data_i`, input, 8: stream byte.
- `byte_ready_o`, output, 1: loader accepts a byte this cycle.
- `imem_we_o`, output, 1: one-cycle instruction-memory write strobe.
- `imem_addr_o`, output, AW = $clog2(IMEM_CAPACITY_KiB*1024): byte address of the write, always word-aligned.
- `imem_wdata_o`, output, ILEN: word to write.
- `cpu_rst_o`, output, 1: reset to the CPU; high while loading.
- `done_o`, output, 1: image loaded successfully; sticky.
- `err_o`, output, 1: load failed; sticky.

## Operation
- A byte is transferred when `byte_valid_i && byte_ready_o` is high at a rising edge.
- Stream format, all fields little-endian: a 4-byte word count N, then N payload words, then a checksum word when `IMEM_LOADER_CHECKSUM_EN` is defined.
- States:
  - `S_LEN`: collect 4 bytes into N. If N > IMEM_WORDS, go to `S_ERR`. If N == 0, go to `S_CSUM` when checksum is enabled, otherwise `S_FIN`. Otherwise go to `S_DATA`.
  - `S_DATA`: each fourth byte completes a word. The word is written at index i, i increments, and the running sum is updated as sum += word mod 2^32. After word N-1, go to `S_CSUM` or `S_FIN`.
  - `S_CSUM`: collect 4 bytes. Go to `S_FIN` if the value equals the sum, otherwise `S_ERR`.
  - `S_FIN`: lasts one cycle, then go to `S_DONE`.
  - `S_DONE`, `S_ERR`: terminal; only reset leaves them.
- `byte_ready_o` is 1 in `S_LEN`, `S_DATA` and `S_CSUM`, and 0 elsewhere.
- Byte lane k (k = 0..3 within the word) lands in bits [8k+7:8k].
- Address width rule: `imem_addr_o` = i << 2, truncated to AW. The word index counter is wide enough to hold IMEM_WORDS.
- Reset mid-load: all state clears and loading restarts at `S_LEN`. Words already written are not erased.
- If `byte_valid_i` stays low, the loader waits indefinitely. There is no timeout.

## Timing
- Reset values: `byte_ready_o`=1, `imem_we_o`=0, `imem_addr_o`=0, `imem_wdata_o`=0, `cpu_rst_o`=1, `done_o`=0, `err_o`=0.
- Write outputs are registered. If the fourth byte of a word is accepted at edge E, then `imem_we_o`, `imem_addr_o` and `imem_wdata_o` are valid in the cycle after E, and `imem_we_o` is high for exactly one cycle.
- Back-to-back bytes: one byte per cycle, giving one write at most every 4 cycles.
- Completion: `S_FIN` is entered at the same edge that issues the final write (or at the final length/checksum byte).
  - `done_o` rises one cycle later, so the last write has committed before the CPU leaves reset.
  - `cpu_rst_o` falls in the same cycle that `done_o` rises.
- In `S_ERR`: `err_o`=1 and `cpu_rst_o` stays 1 permanently.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: the trailing checksum word is required and compared, and a mismatch leads to `S_ERR`. The sum accumulator and `S_CSUM` exist.
- Not defined: no checksum is expected. `S_CSUM` and the accumulator are removed, and the last payload word, or N == 0, goes to `S_FIN`.

## Structure
- Add to `pkg_parameters`: `IMEM_WORDS` = IMEM_CAPACITY_KiB*256 and `IMEM_AW`.
- Add to a shared package: `loader_state_e` enum (`S_LEN`, `S_DATA`, `S_CSUM`, `S_FIN`, `S_DONE`, `S_ERR`).
- One sub-module, `byte_packer`:
  - Implements the 2-bit lane counter and the 32-bit shift register.
  - Emits `word_valid` plus the word when its fourth byte is accepted.
  - Has a `clear` input used between fields.
- The top-level design instantiates `imem_loader` between the external byte source and the existing `imem_if` write side and the CPU reset.

## Test plan
- Length 3, words 0x00000013, 0x00100093, 0x00208133, streamed back-to-back -> writes to addresses 0x0, 0x4 and 0x8 with those words; `done_o`=1 one cycle after the third write; `cpu_rst_o`=0 from that same cycle.
- Same image with `byte_valid_i` toggling every other cycle -> identical writes; each `imem_we_o` is a single cycle.
- Length 0 (no checksum build) -> no writes; `done_o` rises 2 cycles after the fourth length byte.
- Length IMEM_WORDS+1 -> `err_o`=1 after the length field; `byte_ready_o`=0; `cpu_rst_o` stays 1; no writes.
- Checksum build: words 0xFFFFFFFF and 0x00000002 with checksum 0x00000001 -> `done_o`=1. The same words with checksum 0x00000002 -> `err_o`=1.
- `rst_i` pulsed after 6 payload bytes -> outputs return to their reset values immediately; a fresh full stream then loads correctly from address 0.
